// File: rtl/i2c_pkg.sv
// Shared definitions for the two-requester I2C command arbiter:
// FSM state encoding and default timing parameters.
package i2c_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StXfer  = 2'd2,
        StGap   = 2'd3
    } state_e;

    localparam int unsigned DefStartCycles   = 4;
    localparam int unsigned DefGapCycles     = 2048;
    localparam int unsigned DefTimeoutCycles = 262144;

endpackage

// File: rtl/i2c_rr_grant.sv
// Two-way round-robin selector; on a tie the requester not granted last wins.
module i2c_rr_grant (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       sel,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        sel = 1'b0;
        unique case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_q;
            default: sel = 1'b0;
        endcase
        gnt = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    end

    // Starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= sel;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two command requesters onto a single I2C master and relays
// write/read byte handshakes, with a byte-event timeout and post-transfer gap.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned START_CYCLES   = DefStartCycles,
    parameter int unsigned GAP_CYCLES     = DefGapCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] reqValid,
    output logic [1:0] reqReady,
    input  logic [6:0] reqAddr0,
    input  logic [6:0] reqAddr1,
    input  logic [7:0] reqLen0,
    input  logic [7:0] reqLen1,
    input  logic [1:0] reqRdWr,
    input  logic [7:0] txData0,
    input  logic [7:0] txData1,
    input  logic [1:0] txValid,
    output logic [1:0] txReady,
    output logic [7:0] rxData,
    output logic [1:0] rxValid,
    output logic [1:0] done,
    output logic [1:0] error,
    output logic       busy,
    output logic [6:0] mAddr,
    output logic [7:0] mLenMsg,
    output logic       mRdWr,
    output logic       mStart,
    output logic [7:0] mInData,
    output logic       mInValid,
    input  logic       mInReady,
    input  logic [7:0] mOutData,
    input  logic       mOutValid,
    output logic       mOutReady
);

    state_e      state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        owner_q, owner_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic        rdwr_q, rdwr_d;
    logic        in_ready_q, out_valid_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;

    logic       take, sel, done_p, error_p;
    logic       wr_x, rd_x, evt_wr, evt_rd, byte_evt;
    logic [1:0] owner_oh;

    i2c_rr_grant u_rr_grant (
        .clock (clock),
        .reset (reset),
        .req   (reqValid),
        .take  (take),
        .sel   (sel),
        .gnt   (reqReady)
    );

    assign owner_oh = owner_q ? 2'b10 : 2'b01;
    assign wr_x     = (state_q == StXfer) & ~rdwr_q;
    assign rd_x     = (state_q == StXfer) & rdwr_q;
    assign mInValid = wr_x & txValid[owner_q];
    assign mInData  = wr_x ? (owner_q ? txData1 : txData0) : 8'h00;
    // Byte events are rising edges of the master's level handshakes.
    assign evt_wr   = mInValid & mInReady & ~in_ready_q;
    assign evt_rd   = rd_x & mOutValid & ~out_valid_q;
    assign byte_evt = evt_wr | evt_rd;

    assign busy      = (state_q != StIdle);
    assign mStart    = (state_q == StStart);
    assign mAddr     = addr_q;
    assign mLenMsg   = len_q;
    assign mRdWr     = rdwr_q;
    assign mOutReady = 1'b1;
    assign rxData    = rx_data_q;
    assign txReady   = evt_wr ? owner_oh : 2'b00;
    assign rxValid   = rx_valid_q ? owner_oh : 2'b00;
    assign done      = done_p ? owner_oh : 2'b00;
    assign error     = error_p ? owner_oh : 2'b00;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rdwr_d  = rdwr_q;
        take    = 1'b0;
        done_p  = 1'b0;
        error_p = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Grant is a same-cycle pulse, so it must be masked while in reset.
                if (!reset && (|reqValid)) begin
                    take    = 1'b1;
                    owner_d = sel;
                    addr_d  = sel ? reqAddr1 : reqAddr0;
                    len_d   = sel ? reqLen1 : reqLen0;
                    rdwr_d  = reqRdWr[sel];
                    cnt_d   = 8'd0;
                    tmo_d   = 32'd0;
                    cyc_d   = 32'd0;
                    abort_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tmo_d = tmo_q + 32'd1;
                if (cyc_q == START_CYCLES - 1) begin
                    cyc_d   = 32'd0;
                    state_d = (len_q == 8'd0) ? StGap : StXfer;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            StXfer: begin
                if (byte_evt) begin
                    tmo_d = 32'd0;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == len_q) begin
                        state_d = StGap;
                    end
                end else if (tmo_q == TIMEOUT_CYCLES) begin
                    error_p = 1'b1;
                    abort_d = 1'b1;
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StGap: begin
                if (cyc_q == GAP_CYCLES - 1) begin
                    done_p  = ~abort_q;
                    cyc_d   = 32'd0;
                    state_d = StIdle;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cyc_q       <= 32'd0;
            tmo_q       <= 32'd0;
            cnt_q       <= 8'd0;
            abort_q     <= 1'b0;
            owner_q     <= 1'b0;
            addr_q      <= 7'd0;
            len_q       <= 8'd0;
            rdwr_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rdwr_q      <= rdwr_d;
            in_ready_q  <= mInReady;
            out_valid_q <= mOutValid;
            rx_valid_q  <= evt_rd;
            if (evt_rd) begin
                rx_data_q <= mOutData;
            end
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter: write, read, ties, probe,
// timeout abort and mid-transfer reset, with hand-computed expectations.
module tb_i2c_arbiter;

    localparam int unsigned Start = 4;
    localparam int unsigned Gap   = 2048;
    localparam int unsigned Tmo   = 300;

    logic       clock;
    logic       reset;
    logic [1:0] reqValid, reqReady, reqRdWr, txValid, txReady, rxValid, done, error;
    logic [6:0] reqAddr0, reqAddr1, mAddr;
    logic [7:0] reqLen0, reqLen1, txData0, txData1, rxData, mLenMsg, mInData, mOutData;
    logic       busy, mRdWr, mStart, mInValid, mInReady, mOutValid, mOutReady;

    i2c_arbiter #(
        .START_CYCLES   (Start),
        .GAP_CYCLES     (Gap),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqAddr0  (reqAddr0),
        .reqAddr1  (reqAddr1),
        .reqLen0   (reqLen0),
        .reqLen1   (reqLen1),
        .reqRdWr   (reqRdWr),
        .txData0   (txData0),
        .txData1   (txData1),
        .txValid   (txValid),
        .txReady   (txReady),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .done      (done),
        .error     (error),
        .busy      (busy),
        .mAddr     (mAddr),
        .mLenMsg   (mLenMsg),
        .mRdWr     (mRdWr),
        .mStart    (mStart),
        .mInData   (mInData),
        .mInValid  (mInValid),
        .mInReady  (mInReady),
        .mOutData  (mOutData),
        .mOutValid (mOutValid),
        .mOutReady (mOutReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int n_gnt[2], n_tx[2], n_rx[2], n_done[2], n_err[2];
    int n_start, n_glog, n_txl, n_rxl;
    int glog[8];
    logic [7:0] tx_log[8], rx_log[8];
    int gnt_cyc, tx_cyc, done_cyc, err_cyc, busy_cyc;
    logic       s_busy, s_start, s_in_valid, start_seen;
    logic [1:0] s_req_ready;
    logic [6:0] addr_seen;
    logic [7:0] len_seen;
    logic       rdwr_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 2; i++) begin
            n_gnt[i] = 0; n_tx[i] = 0; n_rx[i] = 0; n_done[i] = 0; n_err[i] = 0;
        end
        n_start = 0; n_glog = 0; n_txl = 0; n_rxl = 0;
        gnt_cyc = 0; tx_cyc = 0; done_cyc = 0; err_cyc = 0; busy_cyc = 0;
        start_seen = 1'b0; addr_seen = 7'd0; len_seen = 8'd0; rdwr_seen = 1'b0;
    endtask

    task automatic sample();
        cyc++;
        s_busy = busy; s_start = mStart; s_in_valid = mInValid; s_req_ready = reqReady;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (reqReady[i]) begin
                    n_gnt[i]++; gnt_cyc = cyc;
                    if (n_glog < 8) glog[n_glog] = i;
                    n_glog++;
                end
                if (txReady[i]) begin
                    n_tx[i]++; tx_cyc = cyc;
                    if (n_txl < 8) tx_log[n_txl] = mInData;
                    n_txl++;
                end
                if (rxValid[i]) begin
                    n_rx[i]++;
                    if (n_rxl < 8) rx_log[n_rxl] = rxData;
                    n_rxl++;
                end
                if (done[i]) begin n_done[i]++; done_cyc = cyc; end
                if (error[i]) begin n_err[i]++; err_cyc = cyc; end
            end
            if (mStart) n_start++;
            if (busy) busy_cyc = cyc;
            if (mStart && !start_seen) begin
                start_seen = 1'b1; addr_seen = mAddr; len_seen = mLenMsg; rdwr_seen = mRdWr;
            end
        end
    endtask

    // Sample at the falling edge, return just after the rising edge to drive.
    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!s_busy) break;
        end
        check(tag, {31'd0, s_busy}, 32'd0);
    endtask

    task automatic wait_in_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (s_in_valid) break;
        end
        check(tag, {31'd0, s_in_valid}, 32'd1);
    endtask

    task automatic pulse_in_ready();
        mInReady = 1'b1;
        tick();
        mInReady = 1'b0;
        tick();
    endtask

    logic [7:0] rbytes[3];
    int pend[2];

    initial begin
        reset = 1'b1;
        reqValid = 2'b11; reqAddr0 = '0; reqAddr1 = '0; reqLen0 = '0; reqLen1 = '0;
        reqRdWr = '0; txData0 = '0; txData1 = '0; txValid = 2'b11;
        mInReady = 1'b0; mOutData = '0; mOutValid = 1'b0;
        rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;
        clr_mon();
        #2;
        check("rst_reqReady", {30'd0, reqReady}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {mStart, mInValid, done, error, txReady, rxValid, rxData, mAddr},
              32'd0);
        check("rst_mOutReady", {31'd0, mOutReady}, 32'd1);
        reqValid = 2'b00; txValid = 2'b00;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        tick();

        // Single write from requester 0.
        clr_mon();
        reqAddr0 = 7'h50; reqLen0 = 8'd2; txData0 = 8'hA5; txValid = 2'b01; reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        check("wr_grant", {30'd0, s_req_ready}, 32'd1);
        wait_in_valid("wr_xfer_reached", 20);
        pulse_in_ready();
        txData0 = 8'h3C;
        pulse_in_ready();
        wait_idle("wr_idle", Gap + 50);
        txValid = 2'b00;
        check("wr_mstart_cycles", n_start, Start);
        check("wr_cmd", {rdwr_seen, len_seen, addr_seen}, {1'b0, 8'd2, 7'h50});
        check("wr_txready0", n_tx[0], 2);
        check("wr_txready1", n_tx[1], 0);
        check("wr_data", {tx_log[0], tx_log[1]}, {8'hA5, 8'h3C});
        check("wr_done0", n_done[0], 1);
        check("wr_gap_len", done_cyc - tx_cyc, Gap);

        // Single read by requester 1.
        clr_mon();
        reqAddr1 = 7'h68; reqLen1 = 8'd3; reqRdWr = 2'b10; reqValid = 2'b10;
        tick();
        reqValid = 2'b00;
        check("rd_grant", {30'd0, s_req_ready}, 32'd2);
        for (int i = 0; i < 20 && !s_start; i++) tick();
        for (int i = 0; i < 20 && s_start; i++) tick();
        for (int b = 0; b < 3; b++) begin
            mOutData = rbytes[b]; mOutValid = 1'b1;
            tick();
            mOutValid = 1'b0;
            tick();
        end
        wait_idle("rd_idle", Gap + 50);
        reqRdWr = 2'b00;
        check("rd_cmd", {rdwr_seen, len_seen, addr_seen}, {1'b1, 8'd3, 7'h68});
        check("rd_rxvalid1", n_rx[1], 3);
        check("rd_rxvalid0", n_rx[0], 0);
        check("rd_data", {rx_log[0], rx_log[1], rx_log[2]}, {8'h11, 8'h22, 8'h33});
        check("rd_done", {n_done[1][15:0], n_done[0][15:0]}, {16'd1, 16'd0});
        check("rd_txready", n_tx[0] + n_tx[1], 0);

        // Two back-to-back ties, zero-length so each finishes in START + GAP.
        clr_mon();
        reqLen0 = 8'd0; reqLen1 = 8'd0;
        pend[0] = 2; pend[1] = 2;
        reqValid = 2'b11;
        for (int i = 0; i < 4 * (Gap + Start + 10); i++) begin
            tick();
            for (int k = 0; k < 2; k++) if (s_req_ready[k]) pend[k]--;
            reqValid = {pend[1] > 0, pend[0] > 0};
            if (n_done[0] + n_done[1] == 4 && !s_busy) break;
        end
        check("tie_grants", n_glog, 4);
        check("tie_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]},
              32'h00010001);
        check("tie_done", {n_done[1][15:0], n_done[0][15:0]}, {16'd2, 16'd2});
        check("tie_busy_end", {31'd0, s_busy}, 32'd0);

        // Address-only probe.
        clr_mon();
        reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        wait_idle("probe_idle", Gap + 50);
        check("probe_done0", n_done[0], 1);
        check("probe_latency", done_cyc - gnt_cyc, Start + Gap);
        check("probe_mstart", n_start, Start);
        check("probe_activity", n_tx[0] + n_tx[1] + n_rx[0] + n_rx[1], 0);

        // Write timeout: the master never raises mInReady.
        clr_mon();
        reqLen0 = 8'd1; txData0 = 8'h77; txValid = 2'b01; reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        wait_idle("tmo_idle", Tmo + Gap + 50);
        txValid = 2'b00;
        check("tmo_error0", n_err[0], 1);
        check("tmo_error1", n_err[1], 0);
        check("tmo_when", err_cyc - gnt_cyc, Tmo + 1);
        check("tmo_no_done", n_done[0] + n_done[1], 0);
        check("tmo_busy_fall", busy_cyc - err_cyc, Gap);

        // Reset in the middle of a write by requester 1.
        clr_mon();
        reqLen1 = 8'd2; txData1 = 8'h5A; txValid = 2'b10; reqValid = 2'b10;
        tick();
        reqValid = 2'b00;
        wait_in_valid("mid_xfer_reached", 20);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_mstart_minvalid", {30'd0, mStart, mInValid}, 32'd0);
        check("mid_rst_pulses", {24'd0, done, error, txReady, rxValid}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        txValid = 2'b00;
        clr_mon();
        reqLen0 = 8'd0; reqLen1 = 8'd0; reqValid = 2'b11;
        tick();
        reqValid = 2'b00;
        check("post_rst_grant", {30'd0, s_req_ready}, 32'd1);
        wait_idle("post_rst_idle", Gap + 50);
        check("post_rst_done", {n_done[1][15:0], n_done[0][15:0]}, {16'd0, 16'd1});
        check("post_rst_error", n_err[0] + n_err[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
